// File: rtl/aer_readout_ctrl_pkg.sv
// AER readout controller: shared FSM encoding and address-width helper.
// Imported by the arbiter and the controller top.
package aer_readout_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SERVE,
    PULSE,
    RELEASE
  } state_t;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aer_readout_ctrl_rr_arbiter.sv
// Round-robin row arbiter: first requester at or after ptr, wrapping.
// Purely combinational; one-hot grant plus encoded index.
module aer_readout_ctrl_rr_arbiter
  import aer_readout_ctrl_pkg::*;
#(
  parameter int N = 16,
  parameter int W = addr_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);

  int  k;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = W'(k);
      end
    end
  end

  assign any = found;

endmodule

// File: rtl/aer_readout_ctrl.sv
// AER readout: arbitrates latched pixel rows and emits (row, col) events,
// clearing each served pixel with a column pulse before releasing the row.
module aer_readout_ctrl
  import aer_readout_ctrl_pkg::*;
#(
  parameter int NROWS       = 16,
  parameter int NCOLS       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_W     = 1,
  parameter int RW          = addr_w(NROWS),
  parameter int CW          = addr_w(NCOLS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NROWS*NCOLS-1:0] q_latch,
  output logic [NROWS-1:0]       acky,
  output logic [NCOLS-1:0]       ackx_pulse,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [RW-1:0]          ev_row,
  output logic [CW-1:0]          ev_col,
  output logic                   busy
);

  localparam int NPIX = NROWS * NCOLS;
  localparam int HOLD = SYNC_STAGES + 1;
  localparam int CMAX = (HOLD > PULSE_W) ? HOLD : PULSE_W;
  localparam int CNTW = addr_w(CMAX + 1);

  state_t           state;
  logic [RW-1:0]    row_sel;
  logic [RW-1:0]    ptr;
  logic [RW-1:0]    ptr_next;
  logic [NCOLS-1:0] snap;
  logic [CNTW-1:0]  cnt;

  logic [NPIX-1:0]  sync_q [SYNC_STAGES];
  logic [NPIX-1:0]  qs;
  logic [NROWS-1:0] req;
  logic [NROWS-1:0] grant;
  logic [RW-1:0]    gidx;
  logic             gany;
  logic [NCOLS-1:0] qrow;
  logic [NCOLS-1:0] rem;
  logic [NCOLS-1:0] enc_in;
  logic [NCOLS-1:0] col_oh;
  logic [CW-1:0]    low_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= q_latch;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign qs = sync_q[SYNC_STAGES-1];

  always_comb begin
    req = '0;
    for (int r = 0; r < NROWS; r++) begin
      req[r] = |qs[r*NCOLS +: NCOLS];
    end
  end

  aer_readout_ctrl_rr_arbiter #(
    .N (NROWS),
    .W (RW)
  ) u_rr_arbiter (
    .req   (req),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  always_comb begin
    qrow = '0;
    for (int r = 0; r < NROWS; r++) begin
      if (row_sel == RW'(r)) begin
        qrow = qs[r*NCOLS +: NCOLS];
      end
    end
  end

  // Remaining columns once the current one is cleared.
  always_comb begin
    rem         = snap;
    rem[ev_col] = 1'b0;
  end

  assign enc_in = (state == SETTLE) ? qrow : rem;
  assign col_oh = {{(NCOLS-1){1'b0}}, 1'b1} << ev_col;

  always_comb begin
    low_col = '0;
    for (int c = NCOLS - 1; c >= 0; c--) begin
      if (enc_in[c]) begin
        low_col = CW'(c);
      end
    end
  end

  assign ptr_next = (row_sel == RW'(NROWS - 1)) ? '0 : row_sel + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row_sel    <= '0;
      ptr        <= '0;
      snap       <= '0;
      cnt        <= '0;
      acky       <= '0;
      ackx_pulse <= '0;
      ev_valid   <= 1'b0;
      ev_row     <= '0;
      ev_col     <= '0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gany) begin
            row_sel <= gidx;
            acky    <= grant;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          // Let pixels latched before the grant reach qs.
          if (cnt == CNTW'(HOLD - 1)) begin
            cnt  <= '0;
            snap <= qrow;
            if (|qrow) begin
              ev_valid <= 1'b1;
              ev_row   <= row_sel;
              ev_col   <= low_col;
              state    <= SERVE;
            end else begin
              acky  <= '0;
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SERVE: begin
          if (ev_ready) begin
            ev_valid   <= 1'b0;
            ackx_pulse <= col_oh;
            cnt        <= '0;
            state      <= PULSE;
          end
        end
        PULSE: begin
          if (cnt == CNTW'(PULSE_W - 1)) begin
            ackx_pulse <= '0;
            snap       <= rem;
            cnt        <= '0;
            if (|rem) begin
              ev_valid <= 1'b1;
              ev_col   <= low_col;
              state    <= SERVE;
            end else begin
              acky  <= '0;
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          // Cleared pixels must drain out of qs before re-arbitration.
          if (cnt == CNTW'(HOLD - 1)) begin
            cnt   <= '0;
            ptr   <= ptr_next;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
